driver_complex_multiplier: RTL
==============================

Name: driver_complex_multiplier

Overview:
Stimulus-side counterpart of the complex multiplier monitor. It sources operand transactions on the op_val/op_ready interface and sinks results on the res_val/res_ready interface with a programmable back-pressure pattern. Operands come from a reproducible LFSR sequence. Received results are folded into an XOR checksum, and the block reports done and timeout status. It sits in the testbench between the run controller and the DUT, alongside the monitor.

Parameters:
DATA_WIDTH, 8, operand component width; 4*DATA_WIDTH must be <= 32
NR_TRANS, 16, transactions per run; must be >= 1
LFSR_SEED, 32'h0000_0001, LFSR value loaded on reset and on start; must be non-zero
READY_PATTERN, 8'hFF, rotating res_ready pattern; bit0 is used first
TIMEOUT, 256, idle cycles allowed in DRAIN before error

Ports:
clk  in  1  clock, rising edge
sw_rst  in  1  synchronous active-high reset
start  in  1  single-cycle run request; ignored unless state is IDLE or DONE
op_val  out  1  operand valid
op_ready  in  1  DUT accepts operand
op_data  out  4*DATA_WIDTH  {a_re, a_im, b_re, b_im}
res_val  in  1  DUT result valid
res_ready  out  1  driver accepts result
res_data  in  4*DATA_WIDTH  {re[2DW], im[2DW]}
busy  out  1  high in SEND or DRAIN
done  out  1  high in DONE
error  out  1  sticky timeout flag
sent_cnt  out  $clog2(NR_TRANS+1)  operands accepted by DUT
recv_cnt  out  $clog2(NR_TRANS+1)  results accepted from DUT
res_checksum  out  4*DATA_WIDTH  XOR of accepted res_data

Behaviour:
- Reset (sw_rst=1 at a clk edge) overrides everything, including mid-run:
  - state=IDLE; op_val=0, res_ready=0, busy=0, done=0, error=0.
  - sent_cnt=0, recv_cnt=0, res_checksum=0.
  - LFSR=LFSR_SEED; pattern register=READY_PATTERN; timeout counter=0.
- All outputs are registered. op_val has no combinational path from op_ready.
- LFSR is a 32-bit Galois, right-shifting register:
  - next = (L>>1) ^ (L[0] ? 32'h8020_0003 : 0).
  - op_data = L[4*DATA_WIDTH-1:0].
  - It advances only on an operand transfer (op_val && op_ready).
- States:
  - IDLE: on start, go to SEND. Clear the counters, checksum, error and timeout counter. Reload LFSR=LFSR_SEED and pattern=READY_PATTERN. op_val rises on the cycle after start.
  - SEND: op_val=1. op_data is held stable until a transfer occurs.
    - On each transfer: sent_cnt+1 and the LFSR advances.
    - Back-to-back transfers are allowed, one per cycle.
    - When the transfer making sent_cnt==NR_TRANS happens, op_val deasserts on the next cycle and the state becomes DRAIN. If recv_cnt also reaches NR_TRANS on that edge, the state goes directly to DONE.
  - DRAIN: op_val=0 while results are awaited.
    - Exit to DONE when recv_cnt reaches NR_TRANS.
    - The timeout counter increments each cycle with no result transfer and clears on a result transfer.
    - When it reaches TIMEOUT, set error=1 and go to DONE.
  - DONE: done=1, op_val=0, res_ready=0. Counters and checksum are held. start launches a new run, identical to start from IDLE.
- Result sink:
  - In SEND and DRAIN, res_ready = pattern[0]. The pattern register rotates right by 1 every cycle in those states. In IDLE and DONE, res_ready=0.
  - A result transfer (res_val && res_ready) does recv_cnt+1 and res_checksum ^= res_data.
  - Results may arrive while still in SEND; they are accepted normally.
- Edge cases:
  - res_val in IDLE or DONE is never accepted (res_ready=0), so there is no count change.
  - recv_cnt saturates at NR_TRANS.
  - start while busy is ignored.
  - start and sw_rst together: sw_rst wins.

Test Plan:
1. NR_TRANS=4, op_ready=1 constantly, DUT returns each result 2 cycles later, READY_PATTERN=8'hFF -> op_data sequence is 0x00000001, 0x80200003, 0xC0300002, then the next LFSR value. Four consecutive op transfers occur, then DRAIN, then done=1 with sent_cnt=recv_cnt=4 and checksum equal to the XOR of the four results.
2. op_ready toggling 0/1 every cycle -> op_data and op_val are stable across stalls, the LFSR advances only on transfers, and the run takes 8 cycles to send 4 operands.
3. READY_PATTERN=8'b0000_0101 with res_val held high -> res_ready follows 1,0,1,0,0,0,0,0 repeating, and recv_cnt increments only on the 1-cycles.
4. DUT never returns results, TIMEOUT=16 -> 16 cycles after entering DRAIN: error=1, done=1, recv_cnt=0.
5. sw_rst asserted after 2 operand transfers -> next cycle: op_val=0, state IDLE, counts 0. A following start re-sends 0x00000001 first.
6. start pulsed during SEND, then again in DONE -> the first pulse is ignored. The second starts a new run with cleared counters, checksum and error.

Source files
------------

// File: rtl/driver_complex_multiplier.sv
// driver_complex_multiplier: operand source and result sink for a complex multiplier run
// Ports:
//   clk_i, sw_rst_i        clock and synchronous active-high reset
//   start_i                single-cycle run request, honoured only in IDLE or DONE
//   op_val_o/op_ready_i    operand handshake, op_data_o = {a_re, a_im, b_re, b_im} from the LFSR
//   res_val_i/res_ready_o  result handshake, res_ready_o follows the rotating ready pattern
//   busy_o, done_o         run in progress / run finished
//   error_o                sticky drain timeout
//   sent_cnt_o/recv_cnt_o  accepted operands / results
//   res_checksum_o         XOR of all accepted results
module driver_complex_multiplier #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned NR_TRANS      = 16,
    parameter logic [31:0] LFSR_SEED     = 32'h0000_0001,
    parameter logic [7:0]  READY_PATTERN = 8'hFF,
    parameter int unsigned TIMEOUT       = 256
) (
    input  logic                            clk_i,
    input  logic                            sw_rst_i,
    input  logic                            start_i,
    output logic                            op_val_o,
    input  logic                            op_ready_i,
    output logic [4*DATA_WIDTH-1:0]         op_data_o,
    input  logic                            res_val_i,
    output logic                            res_ready_o,
    input  logic [4*DATA_WIDTH-1:0]         res_data_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic [$clog2(NR_TRANS+1)-1:0]   sent_cnt_o,
    output logic [$clog2(NR_TRANS+1)-1:0]   recv_cnt_o,
    output logic [4*DATA_WIDTH-1:0]         res_checksum_o
);
    localparam int unsigned DW4 = 4 * DATA_WIDTH;
    localparam int unsigned CW  = $clog2(NR_TRANS + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] NR_MAX  = CW'(NR_TRANS);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_e;

    state_e         state_q, state_d;
    logic [31:0]    lfsr_q, lfsr_d;
    logic [7:0]     pat_q, pat_d;
    logic [CW-1:0]  sent_q, sent_d, recv_q, recv_d;
    logic [DW4-1:0] sum_q, sum_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
    logic           op_val_q, op_val_d, res_ready_q, res_ready_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic           op_xfer, res_xfer;

    assign op_xfer  = op_val_q && op_ready_i;
    assign res_xfer = res_val_i && res_ready_q;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        pat_d   = pat_q;
        sent_d  = sent_q;
        recv_d  = recv_q;
        sum_d   = sum_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = SEND;
                    lfsr_d  = LFSR_SEED;
                    pat_d   = READY_PATTERN;
                    sent_d  = '0;
                    recv_d  = '0;
                    sum_d   = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                pat_d = {pat_q[0], pat_q[7:1]};
                if (res_xfer) begin
                    recv_d = (recv_q == NR_MAX) ? recv_q : recv_q + 1'b1;
                    sum_d  = sum_q ^ res_data_i;
                end
                if (state_q == SEND) begin
                    if (op_xfer) begin
                        sent_d = sent_q + 1'b1;
                        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
                        // the final result may land on the same edge as the final operand
                        if (sent_d == NR_MAX) state_d = (recv_d == NR_MAX) ? DONE : DRAIN;
                    end
                end else if (recv_d == NR_MAX) begin
                    state_d = DONE;
                end else begin
                    tmo_d = res_xfer ? '0 : tmo_q + 1'b1;
                    if (tmo_d == TMO_MAX) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
        endcase
        // outputs are computed from next state so every port comes straight from a flop
        busy_d      = (state_d == SEND) || (state_d == DRAIN);
        done_d      = state_d == DONE;
        op_val_d    = state_d == SEND;
        res_ready_d = busy_d && pat_d[0];
    end

    always_ff @(posedge clk_i) begin
        if (sw_rst_i) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            pat_q       <= READY_PATTERN;
            sent_q      <= '0;
            recv_q      <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            op_val_q    <= 1'b0;
            res_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pat_q       <= pat_d;
            sent_q      <= sent_d;
            recv_q      <= recv_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            op_val_q    <= op_val_d;
            res_ready_q <= res_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign op_val_o       = op_val_q;
    assign op_data_o      = lfsr_q[DW4-1:0];
    assign res_ready_o    = res_ready_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = err_q;
    assign sent_cnt_o     = sent_q;
    assign recv_cnt_o     = recv_q;
    assign res_checksum_o = sum_q;
endmodule
